mul_seq_ctrl: RTL and testbench

Sequential unsigned multiplier controller that computes a W×W product by repeatedly driving one shared `mul2b` 2×2 partial-product unit. It walks all 2-bit digit pairs of the operands, shifts each 4-bit partial product into place, and accumulates it. A start/busy/done handshake frames each operation. The block sits between a requester (FSM or register interface) and the small combinational multiplier, trading latency for area.

---
 rtl/mul_pkg.sv | 27 ++
 rtl/mul_seq_ctrl_mul2b.sv | 16 +
 rtl/mul_seq_ctrl.sv | 112 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared constants for the sequential 2x2-digit multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int W_DEFAULT = 8;
    localparam int D_DEFAULT = W_DEFAULT / 2;
    localparam int S_DEFAULT = D_DEFAULT * D_DEFAULT;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int steps(input int w);
        return (w / 2) * (w / 2);
    endfunction

    // Step counter needs at least one bit even when a single step suffices.
    function automatic int cnt_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_ctrl_mul2b.sv
`default_nettype none
// ============================================================================
//  Module   : mul2b
//  Brief    : Combinational 2x2 unsigned multiplier producing a 4-bit product.
//  Revision : 1.0 - initial release
// ============================================================================
module mul2b (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] pp
);

    assign pp = {2'b00, x} * {2'b00, y};

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_ctrl
//  Brief    : WxW unsigned multiplier built from one shared 2x2 unit, one
//             digit pair per cycle, with start/busy/done framing.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int D  = W / 2;
    localparam int S  = steps(W);
    localparam int KW = cnt_width(S);
    localparam int PW = 2 * W;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_p;
    logic [KW-1:0] r_k;

    logic          w_accept;
    logic          w_last;
    logic [KW-1:0] w_i;
    logic [KW-1:0] w_j;
    logic [1:0]    w_x;
    logic [1:0]    w_y;
    logic [3:0]    w_pp;
    logic [KW:0]   w_shamt;
    logic [PW-1:0] w_sum;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_k == KW'(S - 1));
    assign w_i      = r_k / KW'(D);
    assign w_j      = r_k % KW'(D);
    assign w_shamt  = {w_i + w_j, 1'b0};

    // Digit select as a constant-index mux keeps every operand bit in use.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int d = 0; d < D; d++) begin
            if (w_j == KW'(d)) w_x = r_a[2*d +: 2];
            if (w_i == KW'(d)) w_y = r_b[2*d +: 2];
        end
    end

    mul2b u_mul2b (
        .x  (w_x),
        .y  (w_y),
        .pp (w_pp)
    );

    assign w_sum = r_acc + (PW'(w_pp) << w_shamt);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start  ? RUN  : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start  ? RUN  : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_k   <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_k   <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_sum;
            r_k   <= r_k + KW'(1);
            if (w_last) r_p <= w_sum;
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq_ctrl
//  Brief    : Scoreboard bench for mul_seq_ctrl against a product/timing model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam int W  = 8;
    localparam int S  = (W / 2) * (W / 2);
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [PW-1:0] p;

    typedef struct {
        logic [PW-1:0] prod;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            free_at = 0;
    logic [PW-1:0] hold_p = '0;
    bit            armed = 1'b0;
    int            tests = 0;
    int            fails = 0;

    mul_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    // Reference: a request is taken whenever the previous result has been
    // delivered; the product is a*b and appears S edges after acceptance.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
            free_at = cyc + 1;
            hold_p  = '0;
            armed   = 1'b1;
        end else if (start && cyc >= free_at) begin
            sb.push_back('{prod: PW'(a) * PW'(b), due: cyc + S});
            free_at = cyc + S + 1;
        end
    end

    task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            logic exp_done;
            logic exp_busy;
            exp_done = (sb.size() > 0) && (sb[0].due == cyc);
            exp_busy = (sb.size() > 0) && (cyc < sb[0].due);
            if (exp_done) hold_p = sb[0].prod;
            check("busy", PW'(busy), PW'(exp_busy));
            check("done", PW'(done), PW'(exp_done));
            check("p",    p,         hold_p);
            if (exp_done) void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no done expected done within 40 cycles", nm);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        issue(8'h0D, 8'h0B); wait_done("basic");    repeat (3) tick();
        issue(8'hFF, 8'hFF); wait_done("ff_ff");    tick();
        issue(8'h00, 8'hFF); wait_done("zero");     tick();
        issue(8'h80, 8'h02); wait_done("shift");    tick();

        issue(8'd3, 8'd5);
        repeat (4) tick();
        issue(8'd9, 8'd9);
        wait_done("start_busy");
        repeat (3) tick();

        issue(8'hFF, 8'hFF);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();

        issue(8'd2, 8'd3);
        wait_done("b2b_first");
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b_second");
        repeat (2) tick();

        start = 1'b1;
        for (int n = 0; n < 60; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (S + 3) tick();

        for (int n = 0; n < 25; n++) begin
            issue(W'($urandom), W'($urandom));
            wait_done("random");
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
